text_lcd_frame_sequencer: RTL and testbench

Owns a ROWS x COLS shadow character buffer and sequences full-screen updates into text_lcd_ctrl through its byte/command FIFO interface. Host logic writes characters at random positions. The sequencer emits a DDRAM set-address command per row followed by that row's characters, plus a clear-display command on request. It sits between application logic and text_lcd_ctrl, and is the only driver of that controller's data_in/data_valid/is_cmd inputs.

---
 rtl/text_lcd_pkg.sv | 24 ++
 rtl/text_lcd_frame_sequencer_if.sv | 20 ++
 rtl/text_lcd_char_buf.sv | 47 ++++
 rtl/text_lcd_frame_sequencer.sv | 179 +++++++++++++++++
 tb/tb_text_lcd_frame_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/text_lcd_pkg.sv
// Shared constants, sequencer state encoding and a clog2 helper for the text LCD blocks.
package text_lcd_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
    localparam logic [7:0] LCD_CMD_DDRAM  = 8'h80;
    localparam logic [7:0] LCD_ROW1_OFS   = 8'h40;
    localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_CLEAR,
        S_ROW_ADDR,
        S_ROW_CHARS
    } seq_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) width++;
        return width;
    endfunction

endpackage

// File: rtl/text_lcd_frame_sequencer_if.sv
// Byte/command handshake between the frame sequencer (master) and text_lcd_ctrl (slave).
interface text_lcd_frame_sequencer_if;

    logic [7:0] lcd_data_out;
    logic       lcd_data_valid;
    logic       lcd_is_cmd;
    logic       lcd_data_ready;
    logic       lcd_init_done;

    modport master (
        output lcd_data_out, lcd_data_valid, lcd_is_cmd,
        input  lcd_data_ready, lcd_init_done
    );

    modport slave (
        input  lcd_data_out, lcd_data_valid, lcd_is_cmd,
        output lcd_data_ready, lcd_init_done
    );

endinterface

// File: rtl/text_lcd_char_buf.sv
// ROWS x COLS shadow character store: one write port, combinational read, one-cycle blank fill.
module text_lcd_char_buf
    import text_lcd_pkg::*;
#(
    parameter int unsigned COLS = 16,
    parameter int unsigned ROWS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fill,
    input  logic       wr_en,
    input  logic       wr_row,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       rd_row,
    input  logic [5:0] rd_col,
    output logic [7:0] rd_char
);

    logic [7:0] cells [ROWS*COLS];

    // Out-of-range addresses match no cell, so they are dropped without a separate check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ROWS*COLS; i++) cells[i] <= LCD_CHAR_SPACE;
        end else begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (fill)
                        cells[r*COLS + c] <= LCD_CHAR_SPACE;
                    else if (wr_en && wr_row == r[0] && wr_col == c[5:0])
                        cells[r*COLS + c] <= wr_char;
                end
            end
        end
    end

    always_comb begin
        rd_char = LCD_CHAR_SPACE;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (rd_row == r[0] && rd_col == c[5:0]) rd_char = cells[r*COLS + c];
            end
        end
    end

endmodule

// File: rtl/text_lcd_frame_sequencer.sv
// Shadow-buffered full-screen sequencer feeding text_lcd_ctrl.
// Optional periodic refresh: define TEXT_LCD_SEQ_AUTO_REFRESH_EN.
module text_lcd_frame_sequencer
    import text_lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned REFRESH_MS = 100
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_en,
    input  logic                              wr_row,
    input  logic [5:0]                        wr_col,
    input  logic [7:0]                        wr_char,
    input  logic                              refresh_req,
    input  logic                              clear_req,
    text_lcd_frame_sequencer_if.master        lcd,
    output logic                              seq_busy,
    output logic                              frame_done,
    output logic                              dirty
);

    localparam logic [5:0] COL_LAST = 6'(COLS - 1);
    localparam logic       ROW_LAST = 1'(ROWS - 1);

    if (COLS < 1 || COLS > 40 || ROWS < 1 || ROWS > 2 || CLK_HZ < 1000 || REFRESH_MS < 1) begin : g_bad_param
        $error("text_lcd_frame_sequencer: parameter out of range");
    end

    seq_state_e state, state_n;
    logic       row, row_n;
    logic [5:0] col, col_n;
    logic       frame_start, clr_done, last_xfer;
    logic       xfer, wr_ok, load, is_cmd_n, tick;
    logic       pend_clr, pend_ref;
    logic [7:0] byte_n, rd_char;

    assign xfer  = lcd.lcd_data_valid && lcd.lcd_data_ready;
    assign wr_ok = wr_en && !clear_req && (wr_col <= COL_LAST) && (wr_row <= ROW_LAST);

    text_lcd_char_buf #(.COLS(COLS), .ROWS(ROWS)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .fill    (clear_req),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_char (wr_char),
        .rd_row  (row_n),
        .rd_col  (col_n),
        .rd_char (rd_char)
    );

`ifdef TEXT_LCD_SEQ_AUTO_REFRESH_EN
    localparam int unsigned PERIOD = CLK_HZ / 1000 * REFRESH_MS;
    localparam int unsigned TW     = (clog2(PERIOD) < 1) ? 1 : clog2(PERIOD);
    logic [TW-1:0] tmr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  tmr <= '0;
        else if (tick) tmr <= '0;
        else           tmr <= tmr + 1'b1;
    end

    always_comb tick = (tmr == TW'(PERIOD - 1));
`else
    always_comb tick = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        row_n       = row;
        col_n       = col;
        frame_start = 1'b0;
        clr_done    = 1'b0;
        last_xfer   = 1'b0;
        unique case (state)
            S_WAIT_INIT: if (lcd.lcd_init_done) state_n = S_IDLE;
            S_IDLE: begin
                if (pend_clr) begin
                    state_n = S_CLEAR;
                end else if (pend_ref) begin
                    state_n     = S_ROW_ADDR;
                    row_n       = 1'b0;
                    frame_start = 1'b1;
                end
            end
            S_CLEAR: if (xfer) begin
                state_n     = S_ROW_ADDR;
                row_n       = 1'b0;
                frame_start = 1'b1;
                clr_done    = 1'b1;
            end
            S_ROW_ADDR: if (xfer) begin
                state_n = S_ROW_CHARS;
                col_n   = '0;
            end
            S_ROW_CHARS: if (xfer) begin
                if (col == COL_LAST) begin
                    if (row == ROW_LAST) begin
                        state_n   = S_IDLE;
                        last_xfer = 1'b1;
                    end else begin
                        state_n = S_ROW_ADDR;
                        row_n   = 1'b1;
                    end
                end else begin
                    col_n = col + 6'd1;
                end
            end
            default: state_n = S_WAIT_INIT;
        endcase
    end

    // The output register reloads only when empty or draining, so a presented byte never changes.
    always_comb begin
        load     = 1'b0;
        byte_n   = '0;
        is_cmd_n = 1'b0;
        if (!lcd.lcd_data_valid || xfer) begin
            unique case (state_n)
                S_CLEAR: begin
                    load     = 1'b1;
                    byte_n   = LCD_CMD_CLEAR;
                    is_cmd_n = 1'b1;
                end
                S_ROW_ADDR: begin
                    load     = 1'b1;
                    byte_n   = LCD_CMD_DDRAM | (row_n ? LCD_ROW1_OFS : 8'h00);
                    is_cmd_n = 1'b1;
                end
                S_ROW_CHARS: begin
                    load   = 1'b1;
                    byte_n = rd_char;
                end
                default: load = 1'b0;
            endcase
        end
    end

    always_comb seq_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_WAIT_INIT;
            row                <= 1'b0;
            col                <= '0;
            lcd.lcd_data_out   <= '0;
            lcd.lcd_data_valid <= 1'b0;
            lcd.lcd_is_cmd     <= 1'b0;
            frame_done         <= 1'b0;
            dirty              <= 1'b0;
            pend_clr           <= 1'b0;
            pend_ref           <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            col        <= col_n;
            frame_done <= last_xfer;
            if (load) begin
                lcd.lcd_data_out   <= byte_n;
                lcd.lcd_is_cmd     <= is_cmd_n;
                lcd.lcd_data_valid <= 1'b1;
            end else if (xfer) begin
                lcd.lcd_data_valid <= 1'b0;
            end
            if (wr_ok)            dirty <= 1'b1;
            else if (frame_start) dirty <= 1'b0;
            // At frame start the old dirty must not re-arm the request it is being cleared with.
            if (frame_start) pend_ref <= refresh_req | tick;
            else             pend_ref <= pend_ref | refresh_req | dirty | tick;
            if (clear_req)     pend_clr <= 1'b1;
            else if (clr_done) pend_clr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_text_lcd_frame_sequencer.sv
// Directed bench for text_lcd_frame_sequencer: captures every accepted byte and compares whole frames.
module tb_text_lcd_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_row = 1'b0;
    logic [5:0] wr_col = '0;
    logic [7:0] wr_char = '0;
    logic       refresh_req = 1'b0;
    logic       clear_req = 1'b0;
    logic       seq_busy, frame_done, dirty;

    text_lcd_frame_sequencer_if lcd_bus();

    text_lcd_frame_sequencer #(
        .CLK_HZ(50_000_000), .COLS(16), .ROWS(2), .REFRESH_MS(100)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_char     (wr_char),
        .refresh_req (refresh_req),
        .clear_req   (clear_req),
        .lcd         (lcd_bus),
        .seq_busy    (seq_busy),
        .frame_done  (frame_done),
        .dirty       (dirty)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] got_q[$];
    int         n_done = 0;
    int         n_unstable = 0;
    bit         rnd_mode = 1'b0;
    logic [7:0] mdl [2][16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte capture, hold-stability tracking and frame_done counting, all sampled at negedge.
    initial begin
        bit         held;
        logic [8:0] held_val;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held = 1'b0;
            end else begin
                if (held && (!lcd_bus.lcd_data_valid ||
                             {lcd_bus.lcd_is_cmd, lcd_bus.lcd_data_out} != held_val))
                    n_unstable++;
                if (lcd_bus.lcd_data_valid && lcd_bus.lcd_data_ready) begin
                    got_q.push_back({lcd_bus.lcd_is_cmd, lcd_bus.lcd_data_out});
                    held = 1'b0;
                end else if (lcd_bus.lcd_data_valid) begin
                    held = 1'b1;
                    held_val = {lcd_bus.lcd_is_cmd, lcd_bus.lcd_data_out};
                end else begin
                    held = 1'b0;
                end
                if (frame_done) n_done++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) lcd_bus.lcd_data_ready = ($urandom_range(0, 1) != 0);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [8:0] get_byte(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 9'h1FF;
    endfunction

    task automatic model_blank();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) mdl[r][c] = 8'h20;
    endtask

    task automatic check_frame(input string tag, input int base);
        for (int r = 0; r < 2; r++) begin
            check($sformatf("%s_addr%0d", tag, r), 32'(get_byte(base + r*17)),
                  32'({1'b1, (r == 1) ? 8'hC0 : 8'h80}));
            for (int c = 0; c < 16; c++)
                check($sformatf("%s_r%0dc%0d", tag, r, c), 32'(get_byte(base + r*17 + 1 + c)),
                      32'({1'b0, mdl[r][c]}));
        end
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1 refresh_req = 1'b1;
        @(posedge clk); #1 refresh_req = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
    endtask

    task automatic write_char(input logic r, input logic [5:0] c, input logic [7:0] ch);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    initial begin
        int base;
        int part;
        lcd_bus.lcd_init_done  = 1'b0;
        lcd_bus.lcd_data_ready = 1'b1;
        model_blank();

        #12;
        check("rst_valid",  32'(lcd_bus.lcd_data_valid), 32'd0);
        check("rst_data",   32'(lcd_bus.lcd_data_out), 32'd0);
        check("rst_is_cmd", 32'(lcd_bus.lcd_is_cmd), 32'd0);
        check("rst_busy",   32'(seq_busy), 32'd1);
        check("rst_done",   32'(frame_done), 32'd0);
        check("rst_dirty",  32'(dirty), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Requests are held off until the controller reports init done.
        pulse_refresh();
        repeat (20) @(negedge clk);
        check("noinit_bytes", 32'(got_q.size()), 32'd0);
        check("noinit_valid", 32'(lcd_bus.lcd_data_valid), 32'd0);
        check("noinit_busy",  32'(seq_busy), 32'd1);
        @(posedge clk); #1 lcd_bus.lcd_init_done = 1'b1;
        wait_bytes("f1_len", 34, 200);
        check_frame("f1", 0);
        repeat (5) @(negedge clk);
        check("f1_done", 32'(n_done), 32'd1);
        check("f1_idle", 32'(seq_busy), 32'd0);
        check("f1_nomore", 32'(got_q.size()), 32'd34);

        // Column 16 is outside a 16-wide row.
        write_char(1'b0, 6'd16, 8'h58);
        repeat (10) @(negedge clk);
        check("oor_dirty", 32'(dirty), 32'd0);
        check("oor_nobytes", 32'(got_q.size()), 32'd34);

        write_char(1'b1, 6'd3, 8'h41);
        @(negedge clk);
        check("wrA_dirty", 32'(dirty), 32'd1);
        mdl[1][3] = 8'h41;
        wait_bytes("f2_len", 68, 200);
        check_frame("f2", 34);
        check("f2_byte22", 32'(get_byte(34 + 21)), 32'h041);
        repeat (5) @(negedge clk);
        check("f2_dirty", 32'(dirty), 32'd0);
        check("f2_done", 32'(n_done), 32'd2);

        rnd_mode = 1'b1;
        write_char(1'b0, 6'd15, 8'h42);
        mdl[0][15] = 8'h42;
        wait_bytes("f3_len", 102, 3000);
        rnd_mode = 1'b0;
        lcd_bus.lcd_data_ready = 1'b1;
        check_frame("f3", 68);
        repeat (10) @(negedge clk);
        check("f3_stable", 32'(n_unstable), 32'd0);
        check("f3_done", 32'(n_done), 32'd3);
        check("f3_nomore", 32'(got_q.size()), 32'd102);

        // Clear lands while row 0 is streaming; every later-loaded cell is already blank.
        base = 102;
        pulse_refresh();
        wait_bytes("f4_mid", base + 10, 200);
        pulse_clear();
        model_blank();
        wait_bytes("f4_len", base + 69, 400);
        check_frame("f4", base);
        check("f4_clearcmd", 32'(get_byte(base + 34)), 32'h101);
        check_frame("f5", base + 35);
        repeat (10) @(negedge clk);
        check("f5_nomore", 32'(got_q.size()), 32'(base + 69));
        check("f5_done", 32'(n_done), 32'd5);

        base = 171;
        pulse_refresh();
        wait_bytes("f6_mid", base + 20, 200);
        write_char(1'b0, 6'd0, 8'h5A);
        wait_bytes("f6_len", base + 34, 200);
        check_frame("f6", base);
        mdl[0][0] = 8'h5A;
        wait_bytes("f7_len", base + 68, 400);
        check_frame("f7", base + 34);
        check("f7_byte1", 32'(get_byte(base + 35)), 32'h05A);
        repeat (10) @(negedge clk);
        check("f7_nomore", 32'(got_q.size()), 32'(base + 68));
        check("f7_done", 32'(n_done), 32'd7);

        base = 239;
        pulse_refresh();
        wait_bytes("f8_mid", base + 5, 200);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(lcd_bus.lcd_data_valid), 32'd0);
        check("mrst_busy",  32'(seq_busy), 32'd1);
        check("mrst_dirty", 32'(dirty), 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        model_blank();
        part = got_q.size();
        repeat (30) @(negedge clk);
        check("mrst_nobytes", 32'(got_q.size()), 32'(part));
        check("mrst_idle", 32'(seq_busy), 32'd0);
        pulse_refresh();
        wait_bytes("f9_len", part + 34, 200);
        check_frame("f9", part);
        repeat (5) @(negedge clk);
        check("f9_done", 32'(n_done), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
